mips_multicycle_ctrl: RTL

Moore-style control FSM that sequences a multicycle MIPS datapath sharing one unified instruction/data memory. Fetch, decode, address, memory and write-back each take one or more cycles. Adds a memory ready handshake so variable-latency memory stalls the sequence. Sits beside the datapath inside the multicycle processor top, replacing the single-cycle combinational controller.

---
 rtl/mips_mc_pkg.sv | 56 +++++
 rtl/mc_aludec.sv | 42 ++++
 rtl/mips_multicycle_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/mips_mc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_mc_pkg
// Purpose  : Shared states, opcodes, function codes and ALU encodings for the
//            multicycle MIPS controller.
// Revision : 1.0
// ============================================================================
package mips_mc_pkg;

  typedef enum logic [3:0] {
    RST     = 4'd0,
    FETCH   = 4'd1,
    DECODE  = 4'd2,
    MEMADR  = 4'd3,
    MEMRD   = 4'd4,
    MEMWB   = 4'd5,
    MEMWR   = 4'd6,
    RTYPEEX = 4'd7,
    RTYPEWB = 4'd8,
    BEQ     = 4'd9,
    ADDIEX  = 4'd10,
    ADDIWB  = 4'd11,
    JUMP    = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALU operation class requested by the FSM; FUNCT defers to the R-type funct field.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  function automatic logic is_store(input logic [5:0] op);
    return op == OP_SW;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mc_aludec.sv
`default_nettype none
// ============================================================================
// Module   : mc_aludec
// Purpose  : Combinational ALU decoder: aluop + funct -> alucontrol, funct_valid.
// Revision : 1.0
// ============================================================================
import mips_mc_pkg::*;

module mc_aludec (
  input  logic [5:0] funct,
  input  logic [1:0] aluop,
  output logic [2:0] alucontrol,
  output logic       funct_valid
);

  logic [2:0] w_funct_ctl;

  // funct_valid is independent of aluop so DECODE can reject bad R-types early.
  always_comb begin
    w_funct_ctl = ALU_ADD;
    funct_valid = 1'b1;
    case (funct)
      FUNCT_ADD: w_funct_ctl = ALU_ADD;
      FUNCT_SUB: w_funct_ctl = ALU_SUB;
      FUNCT_AND: w_funct_ctl = ALU_AND;
      FUNCT_OR:  w_funct_ctl = ALU_OR;
      FUNCT_SLT: w_funct_ctl = ALU_SLT;
      default:   funct_valid = 1'b0;
    endcase
  end

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_SUB:   alucontrol = ALU_SUB;
      ALUOP_FUNCT: alucontrol = w_funct_ctl;
      default:     alucontrol = ALU_ADD;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mips_multicycle_ctrl
// Purpose  : Moore control FSM for a multicycle MIPS datapath with a unified,
//            variable-latency memory (mem_ready handshake).
// Revision : 1.0
// ============================================================================
import mips_mc_pkg::*;

module mips_multicycle_ctrl #(
  parameter int unsigned IMPLEMENT_BNE = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       memwrite,
  output logic       iord,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [2:0] alucontrol,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic       illegal_op,
  output logic [3:0] state_dbg
);

  state_t     r_state;
  state_t     w_next;
  logic [1:0] w_aluop;
  logic [2:0] w_aluctl;
  logic       w_funct_valid;

  mc_aludec u_aludec (
    .funct       (funct),
    .aluop       (w_aluop),
    .alucontrol  (w_aluctl),
    .funct_valid (w_funct_valid)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= RST;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_aluop    = ALUOP_ADD;
    mem_req    = 1'b0;
    memwrite   = 1'b0;
    iord       = 1'b0;
    irwrite    = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    pcen       = 1'b0;
    illegal_op = 1'b0;
    case (r_state)
      RST: w_next = FETCH;
      FETCH: begin
        mem_req = 1'b1;
        alusrcb = 2'b01;
        // IR load and PC+4 only commit in the cycle memory delivers the word.
        if (mem_ready) begin
          irwrite = 1'b1;
          pcen    = 1'b1;
          w_next  = DECODE;
        end
      end
      DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: w_next = MEMADR;
          OP_RTYPE: begin
            w_next     = w_funct_valid ? RTYPEEX : FETCH;
            illegal_op = ~w_funct_valid;
          end
          OP_BEQ: w_next = BEQ;
          OP_BNE: begin
            if (IMPLEMENT_BNE != 0) begin
              w_next = BEQ;
            end else begin
              w_next     = FETCH;
              illegal_op = 1'b1;
            end
          end
          OP_ADDI: w_next = ADDIEX;
          OP_J:    w_next = JUMP;
          default: begin
            w_next     = FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        w_next  = is_store(op) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) w_next = MEMWB;
      end
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
        w_next   = FETCH;
      end
      MEMWR: begin
        mem_req  = 1'b1;
        iord     = 1'b1;
        memwrite = 1'b1;
        if (mem_ready) w_next = FETCH;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        w_aluop = ALUOP_FUNCT;
        w_next  = RTYPEWB;
      end
      RTYPEWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
        w_next   = FETCH;
      end
      BEQ: begin
        alusrca = 1'b1;
        w_aluop = ALUOP_SUB;
        pcsrc   = 2'b01;
        pcen    = (op == OP_BNE) ? ~zero : zero;
        w_next  = FETCH;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        w_next  = ADDIWB;
      end
      ADDIWB: begin
        regwrite = 1'b1;
        w_next   = FETCH;
      end
      JUMP: begin
        pcsrc  = 2'b10;
        pcen   = 1'b1;
        w_next = FETCH;
      end
      default: w_next = RST;
    endcase
  end

  // Reset state drives every output low, including the ALU control default.
  assign alucontrol = (r_state == RST) ? 3'b000 : w_aluctl;
  assign state_dbg  = r_state;

endmodule
`default_nettype wire
